// File: rtl/pll_sup_pkg.sv
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared state encoding and status widths for the PLL supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_sup_pkg;

    localparam int STATE_W = 3;
    localparam int LOST_W  = 8;
    localparam int RETRY_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } sup_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser, async active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Drives PLL reset, qualifies lock, retries on loss/timeout and
//               latches a fault after repeated lock timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 17
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_reset,
    output logic               pll_ready,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [LOST_W-1:0]  lost_cnt,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic w_lock_s;

    sup_state_t         r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic               r_pll_reset, w_pll_reset_nxt;
    logic               r_ready,     w_ready_nxt;
    logic               r_fault,     w_fault_nxt;
    logic [LOST_W-1:0]  r_lost,      w_lost_nxt;
    logic [RETRY_W-1:0] r_retry,     w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_inc;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_lost      <= '0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_reset <= w_pll_reset_nxt;
            r_ready     <= w_ready_nxt;
            r_fault     <= w_fault_nxt;
            r_lost      <= w_lost_nxt;
            r_retry     <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_pll_reset_nxt = r_pll_reset;
        w_ready_nxt     = r_ready;
        w_fault_nxt     = r_fault;
        w_lost_nxt      = r_lost;
        w_retry_nxt     = r_retry;
        w_retry_inc     = (r_retry == '1) ? r_retry : r_retry + 1'b1;

        // Restart overrides everything, including a coincident lock loss in RUN.
        if (restart) begin
            w_state_nxt     = ST_PLL_RST;
            w_cnt_nxt       = '0;
            w_pll_reset_nxt = 1'b1;
            w_ready_nxt     = 1'b0;
            w_fault_nxt     = 1'b0;
            w_retry_nxt     = '0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    w_pll_reset_nxt = 1'b1;
                    w_ready_nxt     = 1'b0;
                    if (r_cnt == C_RST_LAST) begin
                        w_state_nxt     = ST_WAIT_LOCK;
                        w_cnt_nxt       = '0;
                        w_pll_reset_nxt = 1'b0;
                    end
                end
                ST_WAIT_LOCK: begin
                    w_pll_reset_nxt = 1'b0;
                    if (w_lock_s) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        w_cnt_nxt       = '0;
                        w_retry_nxt     = w_retry_inc;
                        w_pll_reset_nxt = 1'b1;
                        if (int'(w_retry_inc) >= MAX_RETRIES) begin
                            w_state_nxt = ST_FAULT;
                            w_fault_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_PLL_RST;
                        end
                    end
                end
                ST_STABLE: begin
                    // A dropout restarts qualification but is not counted as a retry.
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_ready_nxt = 1'b1;
                        w_retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                    if (!w_lock_s) begin
                        w_state_nxt     = ST_PLL_RST;
                        w_pll_reset_nxt = 1'b1;
                        w_ready_nxt     = 1'b0;
                        w_lost_nxt      = (r_lost == '1) ? r_lost : r_lost + 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b1;
                    w_ready_nxt     = 1'b0;
                    w_fault_nxt     = 1'b1;
                end
                default: begin
                    w_state_nxt     = ST_PLL_RST;
                    w_cnt_nxt       = '0;
                    w_pll_reset_nxt = 1'b1;
                    w_ready_nxt     = 1'b0;
                end
            endcase
        end
    end

    assign pll_reset = r_pll_reset;
    assign pll_ready = r_ready;
    assign fault     = r_fault;
    assign state     = r_state;
    assign lost_cnt  = r_lost;
    assign retry_cnt = r_retry;

endmodule

`default_nettype wire
